axi_rd_slave: RTL and testbench

AXI-style read responder that sits between the on-chip AXI read interconnect and the DDR2 controller's native read port. It accepts one read address request at a time and splits it into native bursts of at most RBURST_LEN words. Returned words are buffered in an internal FIFO and streamed back on the R channel with rready backpressure and rlast on the final beat.

---
 rtl/axi_rd_slave.sv | 145 ++++++++++++++
 tb/tb_axi_rd_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_slave.sv
// AXI-style read responder: takes one AR at a time, splits it into native DDR2
// read bursts and streams the returned words out of a FWFT FIFO on the R channel.
module axi_rd_slave #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16,
  parameter int RBURST_LEN = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]            axi_arlen,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic                  axi_rlast,
  output logic                  mem_rd_req,
  input  logic                  mem_rd_ack,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [7:0]            mem_rd_len,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_data_vld,
  output logic                  busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [8:0]            req_rem_reg, req_rem_next;
  logic [7:0]            rcv_rem_reg, rcv_rem_next;
  logic [8:0]            r_rem_reg, r_rem_next;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  logic                  ar_hs, r_hs, push, fifo_empty, credit_ok;
  logic [7:0]            chunk;
  logic [CNT_W-1:0]      free_cnt;
  logic [8:0]            arlen_words;

  assign arlen_words = (axi_arlen == 8'd0) ? 9'd256 : {1'b0, axi_arlen};
  assign chunk       = (req_rem_reg < 9'(RBURST_LEN)) ? req_rem_reg[7:0] : 8'(RBURST_LEN);
  assign free_cnt    = CNT_W'(FIFO_DEPTH) - count_reg;
  assign credit_ok   = int'(free_cnt) >= int'(chunk);
  assign fifo_empty  = (count_reg == '0);

  assign axi_arready = (state_reg == S_IDLE) && init_end;
  assign ar_hs       = axi_arvalid && axi_arready;
  assign axi_rvalid  = !fifo_empty;
  assign axi_rdata   = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
  assign axi_rlast   = axi_rvalid && (r_rem_reg == 9'd1);
  assign r_hs        = axi_rvalid && axi_rready;
  assign busy        = (state_reg != S_IDLE);

  // Request only once the whole chunk is guaranteed a FIFO slot, so the
  // unstallable native return path can never overflow the buffer.
  assign mem_rd_req  = (state_reg == S_CMD) && (req_rem_reg != 9'd0) && credit_ok;
  assign mem_rd_addr = mem_rd_req ? cur_addr_reg : '0;
  assign mem_rd_len  = mem_rd_req ? chunk : 8'd0;

  // Strobes outside DATA or past the burst length are stray and dropped.
  assign push = (state_reg == S_DATA) && mem_rd_data_vld && (rcv_rem_reg != 8'd0);

  always_comb begin
    state_next    = state_reg;
    cur_addr_next = cur_addr_reg;
    req_rem_next  = req_rem_reg;
    rcv_rem_next  = rcv_rem_reg;
    r_rem_next    = r_rem_reg;
    case (state_reg)
      S_IDLE: begin
        if (ar_hs) begin
          cur_addr_next = axi_araddr;
          req_rem_next  = arlen_words;
          r_rem_next    = arlen_words;
          rcv_rem_next  = 8'd0;
          state_next    = S_CMD;
        end
      end
      S_CMD: begin
        if (mem_rd_req && mem_rd_ack) begin
          cur_addr_next = cur_addr_reg + ADDR_WIDTH'(chunk);
          req_rem_next  = req_rem_reg - {1'b0, chunk};
          rcv_rem_next  = chunk;
          state_next    = S_DATA;
        end
      end
      S_DATA: begin
        if (push) begin
          rcv_rem_next = rcv_rem_reg - 8'd1;
          if (rcv_rem_reg == 8'd1) state_next = (req_rem_reg != 9'd0) ? S_CMD : S_DRAIN;
        end
      end
      default: ;
    endcase
    // The final R beat ends the transaction regardless of FSM position.
    if (r_hs) begin
      r_rem_next = r_rem_reg - 9'd1;
      if (r_rem_reg == 9'd1) state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cur_addr_reg <= '0;
      req_rem_reg  <= '0;
      rcv_rem_reg  <= '0;
      r_rem_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cur_addr_reg <= cur_addr_next;
      req_rem_reg  <= req_rem_next;
      rcv_rem_reg  <= rcv_rem_next;
      r_rem_reg    <= r_rem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (r_hs) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, r_hs})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_slave.sv
// Scoreboard bench for axi_rd_slave: stimulus queues expected R beats and native
// requests; a memory model and an R monitor pop and compare independently.
`timescale 1ns/1ps
module tb_axi_rd_slave;
  localparam int AW  = 27;
  localparam int DW  = 16;
  localparam int RBL = 8;
  localparam int FD  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_end = 1'b0;
  logic          axi_arvalid = 1'b0;
  logic          axi_arready;
  logic [AW-1:0] axi_araddr = '0;
  logic [7:0]    axi_arlen = '0;
  logic          axi_rvalid;
  logic          axi_rready = 1'b0;
  logic [DW-1:0] axi_rdata;
  logic          axi_rlast;
  logic          mem_rd_req;
  logic          mem_rd_ack = 1'b0;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_len;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rd_data_vld = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  axi_rd_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RBURST_LEN(RBL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .init_end(init_end),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len),
    .mem_rd_data(mem_rd_data), .mem_rd_data_vld(mem_rd_data_vld), .busy(busy)
  );

  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } req_t;

  beat_t r_q[$];
  req_t  req_q[$];
  int    checks = 0;
  int    errors = 0;
  int    occ = 0;
  int    req_seen = 0;
  int    mem_words = 0;
  bit    mem_busy = 0;
  bit    chk_idle_next = 0;
  int    rr_mode = 0;
  int    cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // rready pattern: 0 = always ready, 1 = every other cycle, 2 = held low
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    case (rr_mode)
      0:       axi_rready = 1'b1;
      1:       axi_rready = cyc[0];
      default: axi_rready = 1'b0;
    endcase
  end

  // Native memory model: ack at once, 2-cycle latency, returns address as data.
  initial begin
    logic [AW-1:0] a;
    logic [7:0]    l;
    req_t          e;
    forever begin
      @(negedge clk);
      if (mem_rd_req && !rst) begin
        a = mem_rd_addr;
        l = mem_rd_len;
        req_seen++;
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr 0x%0h len %0d, expected none", a, l);
        end else begin
          e = req_q.pop_front();
          chk("req_addr", 32'(a), 32'(e.addr));
          chk("req_len", 32'(l), 32'(e.len));
        end
        mem_busy = 1;
        mem_rd_ack = 1'b1;
        @(negedge clk);
        mem_rd_ack = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < int'(l); i++) begin
          mem_rd_data = DW'(a + AW'(i));
          mem_rd_data_vld = 1'b1;
          occ++;
          mem_words++;
          @(negedge clk);
        end
        mem_rd_data_vld = 1'b0;
        mem_rd_data = '0;
        mem_busy = 0;
        if (req_q.size() > 0 && rr_mode == 0) chk("req_between_chunks", 32'(mem_rd_req), 32'd1);
      end
    end
  end

  // R channel monitor
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (chk_idle_next) begin
        chk_idle_next = 0;
        chk("arready_after_last", 32'(axi_arready), 32'd1);
        chk("busy_after_last", 32'(busy), 32'd0);
      end
      if (axi_rvalid && axi_rready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected none", axi_rdata, axi_rlast);
        end else begin
          e = r_q.pop_front();
          chk("rbeat{last,data}", {15'd0, axi_rlast, axi_rdata}, {15'd0, e.last, e.data});
          if (e.last) chk_idle_next = 1;
        end
        occ--;
      end
      if (occ > FD) begin
        errors++;
        $display("FAIL fifo_overflow: got occupancy %0d, expected <= %0d", occ, FD);
      end
    end
  end

  task automatic ar_handshake(input logic [AW-1:0] addr, input logic [7:0] len, output bit ok);
    ok = 0;
    @(posedge clk); #1;
    axi_arvalid = 1'b1; axi_araddr = addr; axi_arlen = len;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (axi_arready) ok = 1;
    end
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ar_timeout: got arready 0, expected 1 within 100 cycles");
    end
  endtask

  task automatic run_txn(input logic [AW-1:0] addr, input int n, input int mode, input bit stall);
    logic [AW-1:0] a;
    int rem, c, base;
    bit ok;
    rr_mode = stall ? 2 : mode;
    for (int i = 0; i < n; i++) r_q.push_back('{data: DW'(addr + AW'(i)), last: (i == n - 1)});
    a = addr; rem = n;
    while (rem > 0) begin
      c = (rem < RBL) ? rem : RBL;
      req_q.push_back('{addr: a, len: 8'(c)});
      a = a + AW'(c);
      rem -= c;
    end
    base = req_seen;
    ar_handshake(addr, 8'(n), ok);
    if (!ok) begin r_q.delete(); req_q.delete(); return; end
    @(negedge clk);
    chk("req_after_ar", 32'(mem_rd_req), 32'd1);
    if (stall) begin
      repeat (60) @(negedge clk);
      chk("stall_req_count", 32'(req_seen - base), 32'd2);
      chk("stall_req_low", 32'(mem_rd_req), 32'd0);
      chk("stall_rvalid", 32'(axi_rvalid), 32'd1);
      rr_mode = mode;
    end
    for (int k = 0; k < 4000 && r_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (r_q.size() != 0) begin
      errors++;
      $display("FAIL txn_timeout: got %0d beats outstanding, expected 0", r_q.size());
      r_q.delete();
    end
    chk("reqs_all_issued", 32'(req_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500 us");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 32'(axi_arready), 32'd0);
    chk("rst_rvalid", 32'(axi_rvalid), 32'd0);
    chk("rst_rlast", 32'(axi_rlast), 32'd0);
    chk("rst_rdata", 32'(axi_rdata), 32'd0);
    chk("rst_req", 32'(mem_rd_req), 32'd0);
    chk("rst_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_len", 32'(mem_rd_len), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("no_init_arready", 32'(axi_arready), 32'd0);
    @(posedge clk); #1;
    init_end = 1'b1;

    run_txn(27'h100, 8, 0, 0);
    run_txn(27'h2000, 20, 1, 0);
    run_txn(27'h4000, 256, 0, 0);
    run_txn(27'h6000, 24, 0, 1);
    run_txn(27'h7FFFFFF, 1, 0, 0);
    run_txn(27'h7FFFFFF, 2, 1, 0);
    run_txn(27'h7FFFFFF, 16, 0, 0);

    // Reset in the middle of a native burst, with stray data still arriving.
    rr_mode = 2;
    req_q.push_back('{addr: 27'h40, len: 8'd8});
    base = mem_words;
    ar_handshake(27'h40, 8'd8, ok);
    for (int k = 0; k < 50 && mem_words < base + 3; k++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; init_end = 1'b0;
    axi_arvalid = 1'b1; axi_araddr = 27'h500; axi_arlen = 8'd4;
    @(posedge clk); #1;
    rst = 1'b0;
    r_q.delete(); req_q.delete();
    chk("stray_pending", 32'(mem_busy), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("postrst_rvalid", 32'(axi_rvalid), 32'd0);
      chk("postrst_rlast", 32'(axi_rlast), 32'd0);
      chk("postrst_arready", 32'(axi_arready), 32'd0);
      chk("postrst_busy", 32'(busy), 32'd0);
      chk("postrst_req", 32'(mem_rd_req), 32'd0);
    end
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    for (int k = 0; k < 50 && mem_busy; k++) @(negedge clk);
    occ = 0;
    @(posedge clk); #1;
    init_end = 1'b1;
    run_txn(27'h300, 4, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
